// File: rtl/cmd_frame_sequencer_if.sv
// cmd_frame_sequencer_if: word-stream input, frame-buffer read port and frame
// status for cmd_frame_sequencer. The sequencer attaches through the slave
// modport; the producer/consumer side uses master. err_crc exists only when
// CMD_CHECKSUM_EN is defined.
interface cmd_frame_sequencer_if;
    logic        word_stb;
    logic [15:0] word_in;
    logic [5:0]  rd_addr;
    logic [15:0] rd_data;
    logic        frame_valid;
    logic        frame_ack;
    logic [7:0]  frame_cnt;
    logic        busy;
    logic        err_timeout;
    logic        overrun;
`ifdef CMD_CHECKSUM_EN
    logic        err_crc;

    modport master (
        output word_stb, word_in, rd_addr, frame_ack,
        input  rd_data, frame_valid, frame_cnt, busy, err_timeout, overrun, err_crc
    );
    modport slave (
        input  word_stb, word_in, rd_addr, frame_ack,
        output rd_data, frame_valid, frame_cnt, busy, err_timeout, overrun, err_crc
    );
`else
    modport master (
        output word_stb, word_in, rd_addr, frame_ack,
        input  rd_data, frame_valid, frame_cnt, busy, err_timeout, overrun
    );
    modport slave (
        input  word_stb, word_in, rd_addr, frame_ack,
        output rd_data, frame_valid, frame_cnt, busy, err_timeout, overrun
    );
`endif
endinterface

// File: rtl/cmd_frame_sequencer.sv
// cmd_frame_sequencer: assembles REG_MAX-word command frames from a stream of
// 16-bit SPI words. A frame starts with the CM_COMMAND header word; a header
// seen mid-frame restarts the frame. A completed frame is held (writes
// blocked) until the consumer acks it. Gaps longer than TIMEOUT_CYC abort a
// partial frame.
// Optional feature macro: CMD_CHECKSUM_EN -- last word is the mod-2^16 sum of
// the preceding words; a mismatch pulses err_crc and discards the frame.
module cmd_frame_sequencer #(
    parameter logic [15:0] CM_COMMAND  = 16'h434D,
    parameter int          REG_MAX     = 50,
    parameter int          TIMEOUT_CYC = 50000
) (
    input logic                  clk,
    input logic                  rst,
    cmd_frame_sequencer_if.slave bus
);

    localparam int          TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [5:0]  IDX_LAST = 6'(REG_MAX - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    state_t        state;
    logic [5:0]    idx;
    logic [TW-1:0] timer;
    logic          frame_valid_q;
    logic          busy_q;
    logic          err_timeout_q;
    logic          overrun_q;
    logic [7:0]    frame_cnt_q;
    logic [15:0]   rd_data_q;
`ifdef CMD_CHECKSUM_EN
    logic [15:0]   sum;
    logic          err_crc_q;
`endif

    logic [15:0]   mem [0:REG_MAX-1];
    logic          hdr;
    logic          wr_en;
    logic [5:0]    wr_addr;

    assign hdr = bus.word_stb && (bus.word_in == CM_COMMAND);

    // Buffer write port: header goes to slot 0, data to the running index;
    // nothing is written in HOLD or while reset is asserted.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = idx;
        if (!rst) begin
            if (state == S_IDLE && hdr) begin
                wr_en   = 1'b1;
                wr_addr = 6'd0;
            end else if (state == S_COLLECT && bus.word_stb) begin
                wr_en   = 1'b1;
                wr_addr = hdr ? 6'd0 : idx;
            end
        end
    end

    // Frame buffer RAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= bus.word_in;
    end

    // Registered read port; out-of-range addresses read as zero.
    always_ff @(posedge clk) begin
        if (rst)
            rd_data_q <= 16'h0000;
        else if (int'(bus.rd_addr) < REG_MAX)
            rd_data_q <= mem[bus.rd_addr];
        else
            rd_data_q <= 16'h0000;
    end

    // Frame FSM with all status outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            idx           <= 6'd0;
            timer         <= '0;
            frame_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            err_timeout_q <= 1'b0;
            overrun_q     <= 1'b0;
            frame_cnt_q   <= 8'd0;
`ifdef CMD_CHECKSUM_EN
            sum           <= 16'h0000;
            err_crc_q     <= 1'b0;
`endif
        end else begin
            err_timeout_q <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef CMD_CHECKSUM_EN
            err_crc_q     <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (hdr) begin
                        idx    <= 6'd1;
                        timer  <= '0;
                        busy_q <= 1'b1;
                        state  <= S_COLLECT;
`ifdef CMD_CHECKSUM_EN
                        sum    <= bus.word_in;
`endif
                    end
                end
                S_COLLECT: begin
                    if (bus.word_stb) begin
                        timer <= '0;
                        if (hdr) begin
                            // Resync: a header always restarts the frame.
                            idx <= 6'd1;
`ifdef CMD_CHECKSUM_EN
                            sum <= bus.word_in;
`endif
                        end else if (idx == IDX_LAST) begin
                            idx    <= 6'd0;
                            busy_q <= 1'b0;
`ifdef CMD_CHECKSUM_EN
                            if (bus.word_in != sum) begin
                                err_crc_q <= 1'b1;
                                state     <= S_IDLE;
                            end else begin
                                frame_valid_q <= 1'b1;
                                frame_cnt_q   <= frame_cnt_q + 8'd1;
                                state         <= S_HOLD;
                            end
`else
                            frame_valid_q <= 1'b1;
                            frame_cnt_q   <= frame_cnt_q + 8'd1;
                            state         <= S_HOLD;
`endif
                        end else begin
                            idx <= idx + 6'd1;
`ifdef CMD_CHECKSUM_EN
                            sum <= sum + bus.word_in;
`endif
                        end
                    end else if (timer == TMO_LAST) begin
                        // TIMEOUT_CYC idle clocks since the last word.
                        err_timeout_q <= 1'b1;
                        timer         <= '0;
                        idx           <= 6'd0;
                        busy_q        <= 1'b0;
                        state         <= S_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_HOLD: begin
                    // Words arriving while a frame is held are dropped, even
                    // in the cycle the ack releases it.
                    if (bus.word_stb) overrun_q <= 1'b1;
                    if (bus.frame_ack) begin
                        frame_valid_q <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    idx    <= 6'd0;
                    timer  <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_cnt   = frame_cnt_q;
    assign bus.busy        = busy_q;
    assign bus.err_timeout = err_timeout_q;
    assign bus.overrun     = overrun_q;
`ifdef CMD_CHECKSUM_EN
    assign bus.err_crc     = err_crc_q;
`endif

endmodule

// File: tb/tb_cmd_frame_sequencer.sv
// tb_cmd_frame_sequencer: directed and randomized frames against a queue-based
// reference model of frame assembly, hold, timeout and read-back.
module tb_cmd_frame_sequencer;

    localparam logic [15:0] CM  = 16'h434D;
    localparam int          RM  = 50;
    localparam int          TMO = 300;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cmd_frame_sequencer_if bus();

    cmd_frame_sequencer #(.CM_COMMAND(CM), .REG_MAX(RM), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [15:0] q[$];
    logic [15:0] mbuf  [0:63];
    bit          known [0:63];
    bit          holding = 0;
    logic [7:0]  cnt = 8'd0;
    int          idle = 0;
    logic        e_ovr, e_tmo, e_crc;
    logic [5:0]  rd_a = 6'd0;
    int          ovr_pulses = 0;
    int          tmo_pulses = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rnd_word();
        logic [15:0] w;
        do w = 16'($urandom); while (w == CM);
        return w;
    endfunction

    // Effect of one clock edge on the frame as seen from outside.
    task automatic model_step(input logic stb, input logic [15:0] w, input logic ack);
`ifdef CMD_CHECKSUM_EN
        logic [15:0] s;
`endif
        e_ovr = 0; e_tmo = 0; e_crc = 0;
        if (holding) begin
            if (stb) e_ovr = 1;
            if (ack) holding = 0;
        end else if (stb && w == CM) begin
            q.delete(); q.push_back(w);
            mbuf[0] = w; known[0] = 1; idle = 0;
        end else if (stb && q.size() != 0) begin
            mbuf[q.size()] = w; known[q.size()] = 1;
            q.push_back(w); idle = 0;
            if (q.size() == RM) begin
`ifdef CMD_CHECKSUM_EN
                s = 16'h0;
                for (int i = 0; i < RM - 1; i++) s = s + q[i];
                if (s != q[RM-1]) e_crc = 1;
                else
`endif
                begin
                    holding = 1;
                    cnt = cnt + 8'd1;
                end
                q.delete();
            end
        end else if (!stb && q.size() != 0) begin
            idle++;
            if (idle == TMO) begin
                e_tmo = 1;
                q.delete();
            end
        end
    endtask

    // Drive one cycle of inputs, advance one edge, check every output.
    task automatic cyc(input logic stb, input logic [15:0] w, input logic ack);
        logic [15:0] exp_rd;
        bit rd_known;
        bus.word_stb  = stb;
        bus.word_in   = w;
        bus.frame_ack = ack;
        bus.rd_addr   = rd_a;
        rd_known = (int'(rd_a) >= RM) || known[rd_a];
        exp_rd   = (int'(rd_a) < RM) ? mbuf[rd_a] : 16'h0000;
        @(posedge clk); #1;
        model_step(stb, w, ack);
        bus.word_stb  = 1'b0;
        bus.frame_ack = 1'b0;
        if (bus.overrun === 1'b1) ovr_pulses++;
        if (bus.err_timeout === 1'b1) tmo_pulses++;
        chk("frame_valid", 32'(bus.frame_valid), 32'(holding));
        chk("busy", 32'(bus.busy), 32'(q.size() != 0));
        chk("frame_cnt", 32'(bus.frame_cnt), 32'(cnt));
        chk("overrun", 32'(bus.overrun), 32'(e_ovr));
        chk("err_timeout", 32'(bus.err_timeout), 32'(e_tmo));
`ifdef CMD_CHECKSUM_EN
        chk("err_crc", 32'(bus.err_crc), 32'(e_crc));
`endif
        if (rd_known) chk("rd_data", 32'(bus.rd_data), 32'(exp_rd));
    endtask

    // Reset with hostile inputs held active to show reset wins.
    task automatic do_reset(input int n);
        rst = 1'b1;
        bus.word_stb = 1'b1; bus.word_in = CM; bus.frame_ack = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
        chk("rst_frame_valid", 32'(bus.frame_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
        chk("rst_err_timeout", 32'(bus.err_timeout), 32'd0);
        chk("rst_overrun", 32'(bus.overrun), 32'd0);
        bus.word_stb = 1'b0; bus.frame_ack = 1'b0;
        rst = 1'b0;
        q.delete(); holding = 0; cnt = 8'd0; idle = 0;
    endtask

    // Header, RM-2 payload words, then the last word (checksum when enabled).
    task automatic send_frame(input logic [15:0] base, input bit incr, input int gap_max);
        logic [15:0] s, w;
        s = CM;
        cyc(1'b1, CM, 1'b0);
        for (int k = 1; k < RM; k++) begin
            w = incr ? base + 16'(k - 1) : rnd_word();
`ifdef CMD_CHECKSUM_EN
            if (k == RM - 1) w = s;
`endif
            s = s + w;
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) cyc(1'b0, 16'h0, 1'b0);
            cyc(1'b1, w, 1'b0);
        end
    endtask

    task automatic rd(input logic [5:0] a);
        rd_a = a;
        cyc(1'b0, 16'h0, 1'b0);
    endtask

    initial begin
        int o0, t0;
        for (int i = 0; i < 64; i++) begin mbuf[i] = 16'h0; known[i] = 0; end
        bus.word_stb = 1'b0; bus.word_in = 16'h0; bus.frame_ack = 1'b0; bus.rd_addr = 6'd0;

        do_reset(3);

        // Ack and stray words in IDLE are ignored
        cyc(1'b0, 16'h0, 1'b1);
        cyc(1'b1, 16'h1234, 1'b0);

        // Header + 1..49
        send_frame(16'd1, 1'b1, 0);
        chk("f1_valid", 32'(bus.frame_valid), 32'd1);
        chk("f1_cnt", 32'(bus.frame_cnt), 32'd1);
        rd(6'd5);
        chk("f1_rd5", 32'(bus.rd_data), 32'd5);
        rd(6'd0);
        chk("f1_rd0", 32'(bus.rd_data), 32'(CM));

        // Held frame: 3 dropped words, buffer unchanged, then ack with a word
        o0 = ovr_pulses;
        cyc(1'b1, 16'hAAAA, 1'b0);
        cyc(1'b1, CM, 1'b0);
        cyc(1'b1, 16'h5555, 1'b0);
        chk("hold_overruns", 32'(ovr_pulses - o0), 32'd3);
        rd(6'd1);
        chk("hold_rd1", 32'(bus.rd_data), 32'd1);
        cyc(1'b1, 16'h7777, 1'b1);
        chk("ack_overrun", 32'(bus.overrun), 32'd1);
        chk("ack_released", 32'(bus.frame_valid), 32'd0);

        // Header, 10 words, header again, then 100..148
        cyc(1'b1, CM, 1'b0);
        for (int k = 0; k < 10; k++) cyc(1'b1, rnd_word(), 1'b1);
        send_frame(16'd100, 1'b1, 0);
        chk("resync_cnt", 32'(bus.frame_cnt), 32'd2);
        rd(6'd1);
        chk("resync_rd1", 32'(bus.rd_data), 32'd100);
        rd(6'd48);
        chk("resync_rd48", 32'(bus.rd_data), 32'd147);
`ifndef CMD_CHECKSUM_EN
        rd(6'd49);
        chk("resync_rd49", 32'(bus.rd_data), 32'd148);
`endif
        rd(6'd50);
        chk("rd_oob50", 32'(bus.rd_data), 32'd0);
        rd(6'd63);
        chk("rd_oob63", 32'(bus.rd_data), 32'd0);
        rd_a = 6'd0;
        cyc(1'b0, 16'h0, 1'b1);

        // Header + 20 words, then a full timeout interval of silence
        t0 = tmo_pulses;
        cyc(1'b1, CM, 1'b0);
        for (int k = 0; k < 20; k++) cyc(1'b1, rnd_word(), 1'b0);
        repeat (TMO + 10) cyc(1'b0, 16'h0, 1'b0);
        chk("tmo_once", 32'(tmo_pulses - t0), 32'd1);
        chk("tmo_busy", 32'(bus.busy), 32'd0);
        chk("tmo_valid", 32'(bus.frame_valid), 32'd0);

        // Reset at word index 30, then a full frame, then reset mid-HOLD
        cyc(1'b1, CM, 1'b0);
        for (int k = 0; k < 29; k++) cyc(1'b1, rnd_word(), 1'b0);
        do_reset(2);
        send_frame(16'h0, 1'b0, 0);
        chk("post_rst_cnt", 32'(bus.frame_cnt), 32'd1);
        chk("post_rst_valid", 32'(bus.frame_valid), 32'd1);
        do_reset(1);

`ifdef CMD_CHECKSUM_EN
        // Wrong checksum is rejected
        cyc(1'b1, CM, 1'b0);
        for (int k = 1; k < RM - 1; k++) cyc(1'b1, 16'(k), 1'b0);
        cyc(1'b1, 16'hDEAD, 1'b0);
        chk("crc_bad_pulse", 32'(bus.err_crc), 32'd1);
        chk("crc_bad_valid", 32'(bus.frame_valid), 32'd0);
        send_frame(16'h0, 1'b0, 0);
        chk("crc_good_valid", 32'(bus.frame_valid), 32'd1);
        cyc(1'b0, 16'h0, 1'b1);
`endif

        // Randomized frames with gaps, hold-time traffic, reads and late acks
        for (int f = 0; f < 20; f++) begin
            if ($urandom_range(0, 4) == 0) begin
                cyc(1'b1, CM, 1'b0);
                repeat ($urandom_range(1, 30)) cyc(1'b1, rnd_word(), 1'b0);
            end
            rd_a = 6'($urandom_range(0, 63));
            send_frame(16'h0, 1'b0, 3);
            repeat ($urandom_range(0, 4)) cyc(1'($urandom_range(0, 1)), rnd_word(), 1'b0);
            for (int r = 0; r < 3; r++) rd(6'($urandom_range(0, 63)));
            cyc(1'($urandom_range(0, 1)), rnd_word(), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmd_frame_sequencer.md
CMD_FRAME_SEQUENCER -- requirements
Module: cmd_frame_sequencer

Interface
REQ-001 The block SHALL have parameter CM_COMMAND, default 16'h434D (17229), the frame header word.
REQ-002 The block SHALL have parameter REG_MAX, default 50, the words per frame including the header (legal 2..64).
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 50000, the max idle clocks between words inside a frame.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 word_stb  input  1  one-cycle pulse per received 16-bit SPI word, already synchronised to clk.
REQ-007 word_in  input  16  received word, valid when word_stb=1.
REQ-008 rd_addr  input  6  frame buffer read index (0 = header).
REQ-009 rd_data  output  16  frame buffer word at rd_addr, registered.
REQ-010 frame_valid  output  1  complete frame held in the buffer.
REQ-011 frame_ack  input  1  consumer has finished reading the frame.
REQ-012 frame_cnt  output  8  accepted-frame counter.
REQ-013 busy  output  1  high in COLLECT.
REQ-014 err_timeout  output  1  one-cycle pulse when a frame is aborted by timeout.
REQ-015 overrun  output  1  one-cycle pulse when a word is dropped in HOLD.

Function
REQ-016 The FSM SHALL have states IDLE, COLLECT, HOLD.
REQ-017 In IDLE, word_stb with word_in==CM_COMMAND SHALL write the word to index 0, set the word index to 1, and enter COLLECT; other words SHALL be ignored.
REQ-018 In COLLECT, word_stb SHALL write word_in at the word index and increment it.
REQ-019 In COLLECT, word_stb with word_in==CM_COMMAND SHALL resynchronise: write to index 0, set the index to 1, and remain in COLLECT.
REQ-020 The write of index REG_MAX-1 SHALL complete the frame: next cycle frame_valid=1, state HOLD, frame_cnt+1 (8-bit wrap).
REQ-021 In COLLECT, a timer SHALL clear on every word_stb; if it reaches TIMEOUT_CYC without a word_stb, err_timeout SHALL pulse and the state SHALL return to IDLE.
REQ-022 In HOLD, buffer writes SHALL be blocked; each word_stb SHALL pulse overrun and be dropped, header words included.
REQ-023 frame_valid SHALL stay high until frame_ack is sampled high in HOLD; the next cycle frame_valid=0 and state IDLE.
REQ-024 frame_ack outside HOLD SHALL be ignored.
REQ-025 A word_stb in the same cycle as an accepted frame_ack SHALL be treated as in HOLD (dropped, overrun pulse).
REQ-026 rd_data SHALL equal buffer[rd_addr] one clock after rd_addr is presented; rd_addr>=REG_MAX SHALL return 16'h0000.
REQ-027 Buffer contents SHALL be readable in every state; only HOLD guarantees frame consistency.

Reset
REQ-028 rst=1 SHALL force IDLE, word index 0, timer 0, frame_valid=0, busy=0, err_timeout=0, overrun=0, frame_cnt=0, rd_data=0.
REQ-029 Reset SHALL take priority over all inputs, including mid-COLLECT and mid-HOLD (the partial or held frame is discarded, and frame_cnt is not incremented).
REQ-030 Buffer RAM contents SHALL NOT need to be cleared by reset.

Configuration
REQ-031 With CMD_CHECKSUM_EN defined, word REG_MAX-1 SHALL be a checksum: the mod-2^16 sum of words 0..REG_MAX-2.
REQ-032 With CMD_CHECKSUM_EN defined, a mismatch at frame completion SHALL pulse err_crc (an extra 1-bit output), return to IDLE, and leave frame_valid=0 and frame_cnt unchanged.
REQ-033 Without CMD_CHECKSUM_EN, err_crc SHALL not exist and every completed frame SHALL be accepted per REQ-020.

Verification
REQ-034 Header 16'h434D followed by 49 words 1..49 -> frame_valid=1, frame_cnt=1, rd_addr=5 gives rd_data=5 one clock later.
REQ-035 Header, then 10 words, then header again, then 49 words 100..148 -> a single frame; index 1 = 100, index 49 = 148.
REQ-036 Header and 20 words, then TIMEOUT_CYC idle clocks -> err_timeout pulses once, state IDLE, frame_valid stays 0.
REQ-037 Frame held with 3 word_stb and no ack -> 3 overrun pulses, buffer unchanged; frame_ack -> frame_valid=0 next cycle.
REQ-038 rst asserted at word index 30 -> IDLE, frame_cnt=0, and the next full frame is accepted normally.
REQ-039 CMD_CHECKSUM_EN defined with a wrong last word -> err_crc pulses, frame_valid=0; with the correct sum -> frame accepted.
